// File: rtl/proj_div_pkg.sv
// ---------------------------------------------------------------------------
// proj_div_pkg
// Shared definitions for the divider result FIFO: register offsets, STATUS
// bit positions, the error read-back code and the stored result entry.
// Optional feature macro: RESULT_TIMESTAMP_EN adds a 32-bit stamp field to
// every stored entry.
// ---------------------------------------------------------------------------
package proj_div_pkg;

    // Width of the stored quotient/remainder fields; narrower XLEN values
    // are zero-extended into them.
    localparam int RES_W = 32;

`ifdef RESULT_TIMESTAMP_EN
    localparam int TS_W = 32;
`endif

    // Register offsets within the block (wbs_adr_i[5:0])
    localparam logic [5:0] OFF_HEAD_Q = 6'h00;
    localparam logic [5:0] OFF_HEAD_R = 6'h04;
    localparam logic [5:0] OFF_STATUS = 6'h08;
    localparam logic [5:0] OFF_IRQ_EN = 6'h0C;
    localparam logic [5:0] OFF_HEAD_T = 6'h10;

    // STATUS register bit positions (count occupies the low bits)
    localparam int STATUS_EMPTY_BIT = 8;
    localparam int STATUS_FULL_BIT  = 9;
    localparam int STATUS_OVF_BIT   = 10;

    // Returned for reads of unmapped offsets
    localparam logic [31:0] ERR_CODE = 32'h0bad_0bad;

    // One captured divider result
    typedef struct packed {
`ifdef RESULT_TIMESTAMP_EN
        logic [TS_W-1:0]  stamp;
`endif
        logic [RES_W-1:0] quotient;
        logic [RES_W-1:0] remainder;
    } result_entry_t;

endpackage

// File: rtl/proj_sync_fifo.sv
// ---------------------------------------------------------------------------
// proj_sync_fifo
// Small synchronous FIFO with first-word fall-through head output. A push
// while full is dropped (drop_o pulses) unless a pop happens in the same
// cycle, in which case both succeed.
// Ports:
//   clk_i, reset_ni      clock, asynchronous active-low reset
//   push_i, wdata_i      write request and data
//   pop_i                remove head (ignored when empty)
//   head_o               current head entry (stale when empty)
//   full_o, empty_o      occupancy flags
//   drop_o               push rejected this cycle because FIFO is full
//   count_o              current occupancy
//   count_next_o         occupancy after this cycle's push/pop
// ---------------------------------------------------------------------------
module proj_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     drop_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   count_next_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CW'(DEPTH));
    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

    // A pop frees a slot in the same cycle, so push-while-full succeeds when
    // paired with a pop. Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        pop_ok   = pop_i & ~empty_o;
        push_ok  = push_i & (~full_o | pop_ok);
        drop_o   = push_i & ~push_ok;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/proj_div_result_fifo.sv
// ---------------------------------------------------------------------------
// proj_div_result_fifo
// Captures each completed divider result {quotient, remainder} on the rising
// edge of fini_i into a FIFO, exposes it through a Wishbone slave window at
// 0x3xxx_{BASE_SEL}xx and raises irq_o while results are waiting.
// Optional feature macro: RESULT_TIMESTAMP_EN -- a saturating cycle counter,
// cleared by start_i, is stamped onto each entry and readable at HEAD_T.
// Without it HEAD_T reads 0 and start_i is unused.
// Ports:
//   clk_i, reset_ni                 clock, asynchronous active-low reset
//   start_i                         divider start pulse
//   fini_i                          divider done level
//   quotient_i, remainder_i         divider result, valid while fini_i high
//   wbs_stb_i/cyc_i/we_i/sel_i      Wishbone request (sel ignored)
//   wbs_adr_i, wbs_dat_i            Wishbone address / write data
//   wbs_ack_o, wbs_dat_o            Wishbone ack pulse / registered read data
//   irq_o                           registered result-available interrupt
// ---------------------------------------------------------------------------
module proj_div_result_fifo
    import proj_div_pkg::*;
#(
    parameter int         WBW      = 32,
    parameter int         XLEN     = 32,
    parameter int         DEPTH    = 4,
    parameter logic [3:0] BASE_SEL = 4'h1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             fini_i,
    input  logic [XLEN-1:0]  quotient_i,
    input  logic [XLEN-1:0]  remainder_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [WBW/8-1:0] wbs_sel_i,
    input  logic [WBW-1:0]   wbs_adr_i,
    input  logic [WBW-1:0]   wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [WBW-1:0]   wbs_dat_o,
    output logic             irq_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            fini_q, fini_d;
    logic            ack_q, ack_d;
    logic [WBW-1:0]  dat_q, dat_d;
    logic            irq_q, irq_d;
    logic            irq_en_q, irq_en_d;
    logic            overflow_q, overflow_d;

    logic            push, pop, ovf_clear;
    logic            fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0]   count, count_next;
    result_entry_t   push_entry, head_entry;
    logic            bus_req;
    logic [5:0]      reg_off;
    logic [WBW-1:0]  status_word, rd_word;
    logic            unused_bus;

    assign reg_off    = wbs_adr_i[5:0];
    assign unused_bus = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

`ifdef RESULT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    // Free-running stamp: cleared by start_i, saturates instead of wrapping
    // so a very long divide never looks short.
    always_comb begin
        ts_d = ts_q;
        if (start_i) begin
            ts_d = '0;
        end else if (ts_q != '1) begin
            ts_d = ts_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`else
    logic unused_start;
    assign unused_start = start_i;
`endif

    // Build the entry to store; the stamp is the pre-clear counter value so a
    // start_i coinciding with a fini edge does not zero the stored stamp.
    always_comb begin
        push_entry                      = '0;
        push_entry.quotient[XLEN-1:0]   = quotient_i;
        push_entry.remainder[XLEN-1:0]  = remainder_i;
`ifdef RESULT_TIMESTAMP_EN
        push_entry.stamp                = ts_q;
`endif
    end

    proj_sync_fifo #(
        .WIDTH ($bits(result_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .push_i       (push),
        .pop_i        (pop),
        .wdata_i      (push_entry),
        .head_o       (head_entry),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .drop_o       (fifo_drop),
        .count_o      (count),
        .count_next_o (count_next)
    );

    // Read data mux; head registers return 0 when the FIFO is empty because
    // the FIFO's head output is stale in that case.
    always_comb begin
        status_word                   = '0;
        status_word[CW-1:0]           = count;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_OVF_BIT]   = overflow_q;

        rd_word = WBW'(ERR_CODE);
        case (reg_off)
            OFF_HEAD_Q: begin
                rd_word = '0;
                if (!fifo_empty) rd_word[XLEN-1:0] = head_entry.quotient[XLEN-1:0];
            end
            OFF_HEAD_R: begin
                rd_word = '0;
                if (!fifo_empty) rd_word[XLEN-1:0] = head_entry.remainder[XLEN-1:0];
            end
            OFF_STATUS: rd_word = status_word;
            OFF_IRQ_EN: rd_word = WBW'(irq_en_q);
            OFF_HEAD_T: begin
                rd_word = '0;
`ifdef RESULT_TIMESTAMP_EN
                if (!fifo_empty) rd_word = WBW'(head_entry.stamp);
`endif
            end
            default: rd_word = WBW'(ERR_CODE);
        endcase
    end

    // Bus decode and register side effects. Gating on ~ack_q forces a dead
    // cycle after every ack, so a held strobe cannot re-trigger a pop.
    always_comb begin
        fini_d    = fini_i;
        push      = fini_i & ~fini_q;
        bus_req   = wbs_stb_i & wbs_cyc_i & ~ack_q &
                    (wbs_adr_i[31:28] == 4'h3) & (wbs_adr_i[11:8] == BASE_SEL);
        ack_d     = bus_req;
        dat_d     = dat_q;
        pop       = 1'b0;
        ovf_clear = 1'b0;
        irq_en_d  = irq_en_q;
        if (bus_req) begin
            if (wbs_we_i) begin
                if (reg_off == OFF_STATUS) ovf_clear = wbs_dat_i[STATUS_OVF_BIT];
                if (reg_off == OFF_IRQ_EN) irq_en_d = wbs_dat_i[0];
            end else begin
                dat_d = rd_word;
                if (reg_off == OFF_HEAD_R) pop = ~fifo_empty;
            end
        end
        // A new drop outranks a simultaneous clear so no lost result goes unnoticed.
        overflow_d = overflow_q;
        if (ovf_clear) overflow_d = 1'b0;
        if (fifo_drop) overflow_d = 1'b1;
        irq_d = irq_en_q & (count_next != '0);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fini_q     <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            irq_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            fini_q     <= fini_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule
